// File: rtl/osecpu_status_display_pkg.sv
// -----------------------------------------------------------------------------
// osecpu_status_display_pkg
// Shared definitions for the OSECPU status display:
//   BIT_CR_HLT   - bit position of the halt flag inside the OSECPU control register
//   SEG_BLANK    - active-low segment pattern with every segment and dp dark
//   disp_state_e - display FSM codes (RUN / HALT_LO / HALT_HI)
//   cnt_width()  - counter width for a divider, never narrower than one bit
// -----------------------------------------------------------------------------
package osecpu_status_display_pkg;

    localparam int         BIT_CR_HLT = 0;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic [1:0] {
        DISP_RUN     = 2'd0,
        DISP_HALT_LO = 2'd1,
        DISP_HALT_HI = 2'd2
    } disp_state_e;

    // A divider of 1 still needs a one-bit counter so the terminal-count
    // compare (cnt == 0) has something to look at.
    function automatic int cnt_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/osecpu_status_display_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex font: 4-bit nibble to 7 active-high segments.
// Ports:
//   nibble_i [3:0]  value to render (0-9, A, b, C, d, E, F)
//   seg_o    [6:0]  segments g..a, 1 = segment lit
// -----------------------------------------------------------------------------
module hex_to_seg7 (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/osecpu_status_display.sv
// -----------------------------------------------------------------------------
// osecpu_status_display
// Watches the OSECPU status outputs and drives a 4-digit multiplexed 7-segment
// display. While the CPU runs, pc is shown in hex. On the first halt, dr is
// latched, compared against EXPECT_DR, and its low/high halves are paged.
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   dr     [31:0]  OSECPU data result register
//   cr     [7:0]   OSECPU control register (bit BIT_CR_HLT = halted)
//   pc     [15:0]  OSECPU program counter
//   seg    [7:0]   segments, active-low; [7]=dp, [6:0]=g..a
//   segsel [3:0]   digit enables, one-hot active-low; [0]=rightmost digit
//   halted         sticky: halt seen since reset
//   pass           sticky: latched dr matched EXPECT_DR
// -----------------------------------------------------------------------------
module osecpu_status_display
    import osecpu_status_display_pkg::*;
#(
    parameter int          SCAN_DIV  = 12500,
    parameter int          PAGE_DIV  = 50000000,
    parameter logic [31:0] EXPECT_DR = 32'hFFFFFFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dr,
    input  logic [7:0]  cr,
    input  logic [15:0] pc,
    output logic [7:0]  seg,
    output logic [3:0]  segsel,
    output logic        halted,
    output logic        pass
);

    localparam int                SCAN_W    = cnt_width(SCAN_DIV);
    localparam int                PAGE_W    = cnt_width(PAGE_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_DIV - 1);

    disp_state_e       state_q, state_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [PAGE_W-1:0] page_cnt_q, page_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [31:0]       dr_lat_q, dr_lat_d;
    logic              halted_q, halted_d;
    logic              pass_q, pass_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        segsel_q, segsel_d;

    logic [15:0]       value;
    logic [3:0]        nibbles [4];
    logic [6:0]        font_seg;
    logic              dp_lit;
    logic              halt_seen;
    logic              cr_unused;

    // Only the halt bit of cr matters; the rest are folded away here.
    assign cr_unused = ^(cr & ~(8'h01 << BIT_CR_HLT));
    assign halt_seen = cr[BIT_CR_HLT];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DISP_RUN;
            scan_cnt_q <= '0;
            page_cnt_q <= '0;
            digit_q    <= 2'd0;
            dr_lat_q   <= 32'd0;
            halted_q   <= 1'b0;
            pass_q     <= 1'b0;
            seg_q      <= SEG_BLANK;
            segsel_q   <= 4'b1110;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            page_cnt_q <= page_cnt_d;
            digit_q    <= digit_d;
            dr_lat_q   <= dr_lat_d;
            halted_q   <= halted_d;
            pass_q     <= pass_d;
            seg_q      <= seg_d;
            segsel_q   <= segsel_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        page_cnt_d = page_cnt_q;
        dr_lat_d   = dr_lat_q;
        halted_d   = halted_q;
        pass_d     = pass_q;

        // Digit scan runs in every state, independent of the FSM.
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end

        case (state_q)
            DISP_RUN: begin
                if (halt_seen) begin
                    dr_lat_d   = dr;
                    pass_d     = (dr == EXPECT_DR);
                    halted_d   = 1'b1;
                    page_cnt_d = '0;
                    state_d    = DISP_HALT_LO;
                end
            end
            DISP_HALT_LO, DISP_HALT_HI: begin
                // Halt is sticky: dr/cr/pc are no longer looked at here.
                if (page_cnt_q == PAGE_LAST) begin
                    page_cnt_d = '0;
                    state_d    = (state_q == DISP_HALT_LO) ? DISP_HALT_HI : DISP_HALT_LO;
                end else begin
                    page_cnt_d = page_cnt_q + 1'b1;
                end
            end
            default: state_d = DISP_RUN;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        value = pc;
        case (state_q)
            DISP_HALT_LO: value = dr_lat_q[15:0];
            DISP_HALT_HI: value = dr_lat_q[31:16];
            default:      value = pc;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
        assign nibbles[gi] = value[gi*4 +: 4];
    end

    hex_to_seg7 u_font (
        .nibble_i (nibbles[digit_q]),
        .seg_o    (font_seg)
    );

    // halted_q is 0 in RUN, so neither dp can light there.
    assign dp_lit = ((digit_q == 2'd0) && halted_q && pass_q) ||
                    ((digit_q == 2'd3) && (state_q == DISP_HALT_HI));

    always_comb begin
        seg_d    = {~dp_lit, ~font_seg};
        segsel_d = ~(4'b0001 << digit_q);
    end

    assign seg    = seg_q;
    assign segsel = segsel_q;
    assign halted = halted_q;
    assign pass   = pass_q;

endmodule

// File: tb/tb_osecpu_status_display.sv
module tb_osecpu_status_display;
    import osecpu_status_display_pkg::*;

    localparam int SCAN = 2;
    localparam int PAGE = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dr = 32'd0;
    logic [7:0]  cr = 8'd0;
    logic [15:0] pc = 16'd0;
    logic [7:0]  seg;
    logic [3:0]  segsel;
    logic        halted;
    logic        pass;

    int tests = 0;
    int fails = 0;

    // Expected-model context: edge index at which the halt was taken (0 = none),
    // pc value on display while running, latched dr and expected pass flag.
    int          halt_n = 0;
    logic [15:0] pc_v   = 16'h0000;
    logic [31:0] dr_v   = 32'd0;
    logic        pass_v = 1'b0;

    // Hand-written active-low hex font, dp dark.
    logic [7:0] font_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    osecpu_status_display #(
        .SCAN_DIV  (SCAN),
        .PAGE_DIV  (PAGE),
        .EXPECT_DR (32'hFFFFFFFC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dr     (dr),
        .cr     (cr),
        .pc     (pc),
        .seg    (seg),
        .segsel (segsel),
        .halted (halted),
        .pass   (pass)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_segsel"}, {28'd0, segsel}, 32'hE);
        check({tag, "_seg"},    {24'd0, seg},    32'hFF);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_pass"},   {31'd0, pass},   32'd0);
        $display("[TB] %s: segsel=%b seg=%h halted=%b pass=%b", tag, segsel, seg, halted, pass);
    endtask

    // n = number of clock edges since reset was released.
    // Pins after edge n show the digit/value/state held just before edge n.
    task automatic check_display(input int n);
        int          d;
        logic        hi;
        logic        in_halt;
        logic [15:0] val;
        logic [3:0]  nib;
        logic [7:0]  e_seg;
        logic [3:0]  e_sel;
        d       = ((n - 1) / SCAN) % 4;
        in_halt = (halt_n != 0) && (n - 1 >= halt_n);
        hi      = 1'b0;
        val     = pc_v;
        if (in_halt) begin
            hi  = (((n - 1 - halt_n) / PAGE) % 2) == 1;
            val = hi ? dr_v[31:16] : dr_v[15:0];
        end
        nib   = val[d*4 +: 4];
        e_seg = font_lo[nib];
        if (in_halt && d == 0 && pass_v) e_seg[7] = 1'b0;
        if (in_halt && d == 3 && hi)     e_seg[7] = 1'b0;
        e_sel = 4'b1111;
        e_sel[d] = 1'b0;
        check($sformatf("n%0d_segsel", n), {28'd0, segsel}, {28'd0, e_sel});
        check($sformatf("n%0d_seg", n),    {24'd0, seg},    {24'd0, e_seg});
        check($sformatf("n%0d_halted", n), {31'd0, halted},
              {31'd0, (halt_n != 0 && n >= halt_n)});
        check($sformatf("n%0d_pass", n),   {31'd0, pass},
              {31'd0, (halt_n != 0 && n >= halt_n && pass_v)});
        $display("[TB] n=%0d segsel=%b seg=%h halted=%b pass=%b (exp segsel=%b seg=%h)",
                 n, segsel, seg, halted, pass, e_sel, e_seg);
    endtask

    initial begin
        // 1. Reset held for 3 cycles.
        reset = 1'b1;
        pc    = 16'h1234;
        repeat (3) tick();
        check_reset("reset");

        // 2. Running: pc 1234 scanned as 4,3,2,1, no dp.
        reset = 1'b0;
        pc_v  = 16'h1234;
        for (int n = 1; n <= 16; n++) begin
            tick();
            check_display(n);
        end

        // 3. Halt with the passing value; page through low/high/low halves.
        // 5. Inputs scrambled after halt must not disturb anything.
        dr     = 32'hFFFFFFFC;
        cr     = 8'h01 << BIT_CR_HLT;
        halt_n = 17;
        dr_v   = 32'hFFFFFFFC;
        pass_v = 1'b1;
        for (int n = 17; n <= 41; n++) begin
            tick();
            check_display(n);
            if (n == 20) begin
                dr = 32'h12345678;
                cr = 8'h00;
                pc = 16'hFFFF;
            end
        end

        // 6. Reset while in HALT_HI (page toggled to HI at edge 41).
        reset = 1'b1;
        tick();
        check_reset("reset_in_halt_hi");
        reset  = 1'b0;
        halt_n = 0;
        pc_v   = 16'hFFFF;
        pass_v = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_display(n);
        end

        // 4. Halt with a failing value: shows A,2,0,0 with no pass dp.
        dr     = 32'h0000002A;
        cr     = 8'h01 << BIT_CR_HLT;
        halt_n = 9;
        dr_v   = 32'h0000002A;
        pass_v = 1'b0;
        for (int n = 9; n <= 26; n++) begin
            tick();
            check_display(n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
